pipeline_ctrl_bank: RTL

Frame-synchronous, multi-layer control register bank for the compositing pipeline. It sits between the SPI byte receiver and one or more pipeline instances. It decodes a byte-oriented command stream into per-layer shadow registers, then commits all shadows atomically to the active control outputs at the next frame start, so that no frame is rendered with half-updated settings. It generalises the single-layer SPI control set to `NUM_LAYERS` foreground layers and adds double buffering, validation and error reporting.

---
 rtl/pipeline_ctrl_bank.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl_bank.sv
// Multi-layer, frame-synchronous control register bank fed by an SPI byte stream.
// Optional PIPELINE_CTRL_STATUS_EN adds status_byte and a sticky error flag.
module pipeline_ctrl_bank #(
    parameter int PRECISION              = 11,
    parameter int TRANSPARENCY_PRECISION = 3,
    parameter int NUM_LAYERS             = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [7:0]                                cmd_byte,
    input  logic                                      cmd_valid,
    input  logic                                      cmd_abort,
    input  logic                                      frame_start,
    output logic [2*NUM_LAYERS-1:0]                   ctrl_overlay_mode,
    output logic [2*NUM_LAYERS-1:0]                   ctrl_fg_scale,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]       ctrl_fg_offset_x,
    output logic [(PRECISION+1)*NUM_LAYERS-1:0]       ctrl_fg_offset_y,
    output logic [(TRANSPARENCY_PRECISION+1)*NUM_LAYERS-1:0] ctrl_fg_opacity,
    output logic [PRECISION*NUM_LAYERS-1:0]           ctrl_fg_clip_left,
    output logic [PRECISION*NUM_LAYERS-1:0]           ctrl_fg_clip_right,
    output logic [PRECISION*NUM_LAYERS-1:0]           ctrl_fg_clip_top,
    output logic [PRECISION*NUM_LAYERS-1:0]           ctrl_fg_clip_bottom,
    output logic                                      ctrl_fg_freeze,
    output logic                                      commit_pending,
    output logic                                      cmd_error
`ifdef PIPELINE_CTRL_STATUS_EN
    ,
    output logic [7:0]                                status_byte
`endif
);
    localparam int OW = PRECISION + 1;
    localparam int TW = TRANSPARENCY_PRECISION + 1;
    localparam logic [TW-1:0] OPAQ  = TW'(1 << TRANSPARENCY_PRECISION);
    localparam logic [8:0]    OPAQ9 = 9'(1 << TRANSPARENCY_PRECISION);
    localparam logic [4:0]    NL5   = 5'(NUM_LAYERS);

    typedef struct packed {
        logic [1:0]           mode;
        logic [1:0]           scale;
        logic [OW-1:0]        offx;
        logic [OW-1:0]        offy;
        logic [TW-1:0]        opac;
        logic [PRECISION-1:0] cl;
        logic [PRECISION-1:0] cr;
        logic [PRECISION-1:0] ct;
        logic [PRECISION-1:0] cb;
    } layer_t;

    localparam layer_t DEF = '{mode: 2'd0, scale: 2'd0, offx: '0, offy: '0, opac: OPAQ,
                               cl: '0, cr: '0, ct: '0, cb: '0};

    typedef enum logic [1:0] {IDLE, BYTE_HI, BYTE_LO} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_op, r_layer;
    logic [7:0]  r_hi;
    layer_t      r_sh  [NUM_LAYERS];
    layer_t      r_act [NUM_LAYERS];
    logic        r_freeze, r_pending, r_err;
    logic        w_err, w_commit, w_clear, w_wr, w_layer_ok;
    logic [15:0] w_pay;
    logic [TW-1:0] w_opac;

    assign w_layer_ok = {1'b0, r_layer} < NL5;
    assign w_pay      = {r_hi, cmd_byte};
    assign w_opac     = ({1'b0, cmd_byte} > OPAQ9) ? OPAQ : TW'(cmd_byte);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Abort wins over a byte strobe in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_commit    = 1'b0;
        w_clear     = 1'b0;
        w_wr        = 1'b0;
        if (cmd_abort) begin
            w_state_nxt = IDLE;
        end else if (cmd_valid) begin
            case (r_state)
                IDLE: begin
                    case (cmd_byte[7:4])
                        4'h0:                   ;
                        4'hB:                   w_commit = 1'b1;
                        4'hF:                   w_clear  = 1'b1;
                        4'hC, 4'hD, 4'hE:       w_err    = 1'b1;
                        4'h1, 4'h2, 4'h5, 4'hA: w_state_nxt = BYTE_LO;
                        default:                w_state_nxt = BYTE_HI;
                    endcase
                end
                BYTE_HI: w_state_nxt = BYTE_LO;
                BYTE_LO: begin
                    w_state_nxt = IDLE;
                    if (r_op != 4'hA && !w_layer_ok)               w_err = 1'b1;
                    else if (r_op == 4'h1 && cmd_byte[1:0] == 2'd3) w_err = 1'b1;
                    else                                            w_wr  = 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_valid && r_state == IDLE)    {r_op, r_layer} <= cmd_byte;
        if (cmd_valid && r_state == BYTE_HI) r_hi <= cmd_byte;
    end

    // Nonblocking semantics give the commit the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < NUM_LAYERS; l++) begin
                r_sh[l]  <= DEF;
                r_act[l] <= DEF;
            end
            r_freeze  <= 1'b0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_err;
            if (frame_start && r_pending)
                for (int l = 0; l < NUM_LAYERS; l++) r_act[l] <= r_sh[l];
            if (w_commit)         r_pending <= 1'b1;
            else if (frame_start) r_pending <= 1'b0;
            if (w_wr && r_op == 4'hA) r_freeze <= cmd_byte[0];
            for (int l = 0; l < NUM_LAYERS; l++) begin
                if (w_clear) begin
                    r_sh[l] <= DEF;
                end else if (w_wr && {1'b0, r_layer} == 5'(l)) begin
                    case (r_op)
                        4'h1:    r_sh[l].mode  <= cmd_byte[1:0];
                        4'h2:    r_sh[l].scale <= cmd_byte[1:0];
                        4'h3:    r_sh[l].offx  <= OW'(w_pay);
                        4'h4:    r_sh[l].offy  <= OW'(w_pay);
                        4'h5:    r_sh[l].opac  <= w_opac;
                        4'h6:    r_sh[l].cl    <= PRECISION'(w_pay);
                        4'h7:    r_sh[l].cr    <= PRECISION'(w_pay);
                        4'h8:    r_sh[l].ct    <= PRECISION'(w_pay);
                        4'h9:    r_sh[l].cb    <= PRECISION'(w_pay);
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_out
        assign ctrl_overlay_mode[2*g +: 2]          = r_act[g].mode;
        assign ctrl_fg_scale[2*g +: 2]              = r_act[g].scale;
        assign ctrl_fg_offset_x[OW*g +: OW]         = r_act[g].offx;
        assign ctrl_fg_offset_y[OW*g +: OW]         = r_act[g].offy;
        assign ctrl_fg_opacity[TW*g +: TW]          = r_act[g].opac;
        assign ctrl_fg_clip_left[PRECISION*g +: PRECISION]   = r_act[g].cl;
        assign ctrl_fg_clip_right[PRECISION*g +: PRECISION]  = r_act[g].cr;
        assign ctrl_fg_clip_top[PRECISION*g +: PRECISION]    = r_act[g].ct;
        assign ctrl_fg_clip_bottom[PRECISION*g +: PRECISION] = r_act[g].cb;
    end

    assign ctrl_fg_freeze = r_freeze;
    assign commit_pending = r_pending;
    assign cmd_error      = r_err;

`ifdef PIPELINE_CTRL_STATUS_EN
    logic r_err_sticky;
    always_ff @(posedge clk) begin
        if (!rst_n)       r_err_sticky <= 1'b0;
        else if (w_clear) r_err_sticky <= 1'b0;
        else if (w_err)   r_err_sticky <= 1'b1;
    end
    // Every field is already a flop, so the concatenation is registered.
    assign status_byte = {r_pending, r_err_sticky, r_freeze, 1'b0, 4'(NUM_LAYERS - 1)};
`endif
endmodule
